// File: rtl/mod_demod_pkg.sv
// rtl/mod_demod_pkg.sv - shared widths, inversion key and XOR helper for mod_demod_unit
package mod_demod_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF  = 16;

  localparam logic [DATA_WIDTH_DEF-1:0] KEY_INVERT = {DATA_WIDTH_DEF{1'b1}};

  function automatic logic [DATA_WIDTH_DEF-1:0] xor_key(
    input logic [DATA_WIDTH_DEF-1:0] data,
    input logic [DATA_WIDTH_DEF-1:0] key
  );
    return data ^ key;
  endfunction

endpackage

// File: rtl/mod_demod_unit_if.sv
// rtl/mod_demod_unit_if.sv - data/key inputs and loopback results of mod_demod_unit
interface mod_demod_unit_if
  import mod_demod_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] mod_key;
  logic [DATA_WIDTH-1:0] demod_key;
  logic [DATA_WIDTH-1:0] modulated_signal;
  logic                  mod_valid;
  logic [DATA_WIDTH-1:0] demodulated_data;
  logic                  demod_valid;
  logic                  mismatch;
  logic                  err_sticky;
  logic [CNT_WIDTH-1:0]  err_count;

  modport master (
    output in_valid, data_in, mod_key, demod_key,
    input  modulated_signal, mod_valid, demodulated_data, demod_valid,
           mismatch, err_sticky, err_count
  );

  modport slave (
    input  in_valid, data_in, mod_key, demod_key,
    output modulated_signal, mod_valid, demodulated_data, demod_valid,
           mismatch, err_sticky, err_count
  );

endinterface

// File: rtl/mod_demod_unit_xor_key_stage.sv
// rtl/mod_demod_unit_xor_key_stage.sv - registered XOR-with-key stage carrying a side-band word
module xor_key_stage #(
  parameter int WIDTH      = 16,
  parameter int SIDE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [WIDTH-1:0]      key,
  input  logic [SIDE_WIDTH-1:0] in_side,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SIDE_WIDTH-1:0] out_side
);

  // Data and side-band hold across idle cycles so downstream sees the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_side  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data ^ key;
        out_side <= in_side;
      end
    end
  end

endmodule

// File: rtl/mod_demod_unit.sv
// rtl/mod_demod_unit.sv - XOR modulator/demodulator loopback with mismatch checker
module mod_demod_unit
  import mod_demod_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mod_demod_unit_if.slave  bus
);

  logic                  mod_valid_q;
  logic [DATA_WIDTH-1:0] mod_data_q;
  logic [DATA_WIDTH-1:0] orig_q;
  logic                  demod_valid_q;
  logic [DATA_WIDTH-1:0] demod_data_q;
  logic [DATA_WIDTH-1:0] orig2_q;
  logic                  mismatch_q;
  logic                  sticky_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  miss;

  xor_key_stage #(.WIDTH(DATA_WIDTH), .SIDE_WIDTH(DATA_WIDTH)) u_mod (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_data   (bus.data_in),
    .key       (bus.mod_key),
    .in_side   (bus.data_in),
    .out_valid (mod_valid_q),
    .out_data  (mod_data_q),
    .out_side  (orig_q)
  );

  xor_key_stage #(.WIDTH(DATA_WIDTH), .SIDE_WIDTH(DATA_WIDTH)) u_demod (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mod_valid_q),
    .in_data   (mod_data_q),
    .key       (bus.demod_key),
    .in_side   (orig_q),
    .out_valid (demod_valid_q),
    .out_data  (demod_data_q),
    .out_side  (orig2_q)
  );

  assign miss = demod_valid_q && (demod_data_q != orig2_q);

  // Counter saturates at all-ones so a long failing run never reads as clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      mismatch_q <= miss;
      if (miss) begin
        sticky_q <= 1'b1;
        if (count_q != {CNT_WIDTH{1'b1}}) count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.modulated_signal = mod_data_q;
  assign bus.mod_valid        = mod_valid_q;
  assign bus.demodulated_data = demod_data_q;
  assign bus.demod_valid      = demod_valid_q;
  assign bus.mismatch         = mismatch_q;
  assign bus.err_sticky       = sticky_q;
  assign bus.err_count        = count_q;

endmodule

// File: tb/tb_mod_demod_unit.sv
// tb/tb_mod_demod_unit.sv - vector table, hand sequences and random run against a history-based model
module tb_mod_demod_unit;
  import mod_demod_pkg::*;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int HMAX = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_demod_unit_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  mod_demod_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          r;
    logic          v;
    logic [DW-1:0] d;
    logic [DW-1:0] mk;
    logic [DW-1:0] dk;
    logic          emv;
    logic [DW-1:0] emod;
    logic          edv;
    logic [DW-1:0] edem;
    logic          emm;
    logic          est;
    logic [CW-1:0] ecnt;
  } vec_t;

  vec_t tbl[21];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rstc  = 0;

  logic          hv  [HMAX];
  logic [DW-1:0] hd  [HMAX];
  logic [DW-1:0] hmk [HMAX];
  logic [DW-1:0] hdk [HMAX];

  logic          e_mv, e_dv, e_mm, e_st;
  logic [DW-1:0] e_mod, e_dem;
  logic [CW-1:0] e_cnt;

  function automatic vec_t mkv(
    input logic r, input logic v, input logic [DW-1:0] d,
    input logic [DW-1:0] mk, input logic [DW-1:0] dk,
    input logic emv, input logic [DW-1:0] emod,
    input logic edv, input logic [DW-1:0] edem,
    input logic emm, input logic est, input logic [CW-1:0] ecnt
  );
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.mk = mk; t.dk = dk;
    t.emv = emv; t.emod = emod; t.edv = edv; t.edem = edem;
    t.emm = emm; t.est = est; t.ecnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs derived from the input history since the last reset:
  // a word accepted in cycle j appears modulated after j, demodulated (with
  // the demod key of cycle j+1) after j+1, and is judged after j+2.
  task automatic model();
    int n;
    n = 0;
    e_mv = (cyc - 1 >= rstc) ? hv[cyc-1] : 1'b0;
    e_dv = (cyc - 2 >= rstc) ? hv[cyc-2] : 1'b0;
    e_mod = '0;
    for (int j = cyc - 1; j >= rstc; j--)
      if (hv[j]) begin e_mod = xor_key(hd[j], hmk[j]); break; end
    e_dem = '0;
    for (int j = cyc - 2; j >= rstc; j--)
      if (hv[j]) begin e_dem = xor_key(xor_key(hd[j], hmk[j]), hdk[j+1]); break; end
    e_mm = (cyc - 3 >= rstc) && hv[cyc-3] && (hmk[cyc-3] != hdk[cyc-2]);
    for (int j = rstc; j <= cyc - 3; j++)
      if (hv[j] && (hmk[j] != hdk[j+1])) n++;
    e_cnt = (n > 15) ? 4'hF : n[CW-1:0];
    e_st  = (n > 0);
  endtask

  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic [DW-1:0] mk, input logic [DW-1:0] dk);
    rst = r;
    bus.in_valid = v; bus.data_in = d; bus.mod_key = mk; bus.demod_key = dk;
    hv[cyc] = v; hd[cyc] = d; hmk[cyc] = mk; hdk[cyc] = dk;
    @(posedge clk);
    #1;
    cyc++;
    if (r) rstc = cyc;
    model();
    chk("m_mod_valid",   32'(bus.mod_valid),        32'(e_mv));
    chk("m_modulated",   32'(bus.modulated_signal), 32'(e_mod));
    chk("m_demod_valid", 32'(bus.demod_valid),      32'(e_dv));
    chk("m_demodulated", 32'(bus.demodulated_data), 32'(e_dem));
    chk("m_mismatch",    32'(bus.mismatch),         32'(e_mm));
    chk("m_err_sticky",  32'(bus.err_sticky),       32'(e_st));
    chk("m_err_count",   32'(bus.err_count),        32'(e_cnt));
  endtask

  initial begin
    tbl[0]  = mkv(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 4'd0);
    tbl[1]  = mkv(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 4'd0);
    tbl[2]  = mkv(0, 1, 16'h1234, KEY_INVERT, KEY_INVERT, 1, 16'hEDCB, 0, 16'h0000, 0, 0, 4'd0);
    tbl[3]  = mkv(0, 0, 16'h0000, KEY_INVERT, KEY_INVERT, 0, 16'hEDCB, 1, 16'h1234, 0, 0, 4'd0);
    tbl[4]  = mkv(0, 0, 16'h0000, KEY_INVERT, KEY_INVERT, 0, 16'hEDCB, 0, 16'h1234, 0, 0, 4'd0);
    tbl[5]  = mkv(0, 1, 16'h0000, 16'hA5A5, 16'hA5A5, 1, 16'hA5A5, 0, 16'h1234, 0, 0, 4'd0);
    tbl[6]  = mkv(0, 1, 16'hFFFF, 16'hA5A5, 16'hA5A5, 1, 16'h5A5A, 1, 16'h0000, 0, 0, 4'd0);
    tbl[7]  = mkv(0, 1, 16'h5A5A, 16'hA5A5, 16'hA5A5, 1, 16'hFFFF, 1, 16'hFFFF, 0, 0, 4'd0);
    tbl[8]  = mkv(0, 0, 16'h0000, 16'hA5A5, 16'hA5A5, 0, 16'hFFFF, 1, 16'h5A5A, 0, 0, 4'd0);
    tbl[9]  = mkv(0, 0, 16'h0000, 16'hA5A5, 16'hA5A5, 0, 16'hFFFF, 0, 16'h5A5A, 0, 0, 4'd0);
    tbl[10] = mkv(0, 1, 16'h1111, 16'hFFFF, 16'hFFFE, 1, 16'hEEEE, 0, 16'h5A5A, 0, 0, 4'd0);
    tbl[11] = mkv(0, 1, 16'h2222, 16'hFFFF, 16'hFFFE, 1, 16'hDDDD, 1, 16'h1110, 0, 0, 4'd0);
    tbl[12] = mkv(0, 1, 16'h3333, 16'hFFFF, 16'hFFFE, 1, 16'hCCCC, 1, 16'h2223, 1, 1, 4'd1);
    tbl[13] = mkv(0, 0, 16'h0000, 16'hFFFF, 16'hFFFE, 0, 16'hCCCC, 1, 16'h3332, 1, 1, 4'd2);
    tbl[14] = mkv(0, 0, 16'h0000, 16'hFFFF, 16'hFFFE, 0, 16'hCCCC, 0, 16'h3332, 1, 1, 4'd3);
    tbl[15] = mkv(0, 0, 16'h0000, KEY_INVERT, KEY_INVERT, 0, 16'hCCCC, 0, 16'h3332, 0, 1, 4'd3);
    tbl[16] = mkv(0, 1, 16'h0001, KEY_INVERT, KEY_INVERT, 1, 16'hFFFE, 0, 16'h3332, 0, 1, 4'd3);
    tbl[17] = mkv(0, 0, 16'h0000, KEY_INVERT, KEY_INVERT, 0, 16'hFFFE, 1, 16'h0001, 0, 1, 4'd3);
    tbl[18] = mkv(0, 1, 16'h0002, KEY_INVERT, KEY_INVERT, 1, 16'hFFFD, 0, 16'h0001, 0, 1, 4'd3);
    tbl[19] = mkv(0, 0, 16'h0000, KEY_INVERT, KEY_INVERT, 0, 16'hFFFD, 1, 16'h0002, 0, 1, 4'd3);
    tbl[20] = mkv(0, 0, 16'h0000, KEY_INVERT, KEY_INVERT, 0, 16'hFFFD, 0, 16'h0002, 0, 1, 4'd3);

    bus.in_valid = 1'b0; bus.data_in = '0; bus.mod_key = '0; bus.demod_key = '0;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].mk, tbl[i].dk);
      chk("t_mod_valid",   32'(bus.mod_valid),        32'(tbl[i].emv));
      chk("t_modulated",   32'(bus.modulated_signal), 32'(tbl[i].emod));
      chk("t_demod_valid", 32'(bus.demod_valid),      32'(tbl[i].edv));
      chk("t_demodulated", 32'(bus.demodulated_data), 32'(tbl[i].edem));
      chk("t_mismatch",    32'(bus.mismatch),         32'(tbl[i].emm));
      chk("t_err_sticky",  32'(bus.err_sticky),       32'(tbl[i].est));
      chk("t_err_count",   32'(bus.err_count),        32'(tbl[i].ecnt));
    end

    // Mid-stream reset with mismatching keys: nothing in flight may survive.
    step(0, 1, 16'h0AAA, 16'hFFFF, 16'hFFFE);
    step(0, 1, 16'h0BBB, 16'hFFFF, 16'hFFFE);
    step(1, 1, 16'h0CCC, 16'hFFFF, 16'hFFFE);
    chk("rst_mod_valid",   32'(bus.mod_valid),        32'h0);
    chk("rst_demod_valid", 32'(bus.demod_valid),      32'h0);
    chk("rst_modulated",   32'(bus.modulated_signal), 32'h0);
    chk("rst_demodulated", 32'(bus.demodulated_data), 32'h0);
    chk("rst_err_count",   32'(bus.err_count),        32'h0);
    chk("rst_err_sticky",  32'(bus.err_sticky),       32'h0);
    step(0, 0, 16'h0000, 16'hFFFF, 16'hFFFE);
    chk("rst_no_mismatch", 32'(bus.mismatch), 32'h0);
    step(0, 1, 16'h0DDD, KEY_INVERT, KEY_INVERT);
    chk("post_rst_mod", 32'(bus.modulated_signal), 32'h0000F222);
    step(0, 0, 16'h0000, KEY_INVERT, KEY_INVERT);
    chk("post_rst_demod", 32'(bus.demodulated_data), 32'h00000DDD);
    chk("post_rst_dvalid", 32'(bus.demod_valid), 32'h1);
    step(0, 0, 16'h0000, KEY_INVERT, KEY_INVERT);
    step(0, 0, 16'h0000, KEY_INVERT, KEY_INVERT);
    chk("post_rst_count", 32'(bus.err_count), 32'h0);

    // Saturation: 20 failing words against a 4-bit counter.
    for (int i = 0; i < 20; i++)
      step(0, 1, 16'(i * 37), 16'hFFFF, 16'h0000);
    for (int i = 0; i < 3; i++)
      step(0, 0, 16'h0000, 16'hFFFF, 16'h0000);
    chk("sat_count",  32'(bus.err_count),  32'hF);
    chk("sat_sticky", 32'(bus.err_sticky), 32'h1);

    step(1, 0, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic v;
      logic [DW-1:0] d, mk, dk;
      r  = ($urandom_range(0, 49) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = 16'($urandom);
      mk = ($urandom_range(0, 2) == 0) ? KEY_INVERT : 16'($urandom);
      dk = ($urandom_range(0, 5) == 0) ? 16'($urandom) : mk;
      step(r, v, d, mk, dk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
